network_ejector: RTL and testbench
==================================

Name: network_ejector

Overview:
- Terminal stage of a NoC router output port. Accepts flits from the network over per-virtual-network ready/valid. Buffers them in one FIFO per virtual network (VN).
- A round-robin arbiter that is packet-atomic forwards whole packets to a single local consumer stream.
- Sits directly downstream of the network_if manager side; the ejector agent bench drives it.

Parameters:
- FlitWidth, 64, flit payload width.
- FlitTypeWidth, 2, flit type width; encoding is in the package.
- BroadcastWidth, 1, broadcast tag width; carried through unchanged.
- VirtualNetworkOrChannelIdWidth, 2, VN identifier width.
- NumberOfVirtualNetworksOrChannels, 3, number of VNs; must be ≤ 2^VirtualNetworkOrChannelIdWidth.
- FifoDepth, 4, flits per VN FIFO; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- noc_valid_i  in  1  network flit valid.
- noc_ready_o  out  NumberOfVirtualNetworksOrChannels  per-VN ready.
- noc_flit_i  in  FlitWidth  flit data.
- noc_flit_type_i  in  FlitTypeWidth  flit type.
- noc_broadcast_i  in  BroadcastWidth  broadcast tag.
- noc_virtual_identifier_i  in  VirtualNetworkOrChannelIdWidth  target VN.
- out_valid_o  out  1  local flit valid.
- out_ready_i  in  1  local consumer ready.
- out_flit_o  out  FlitWidth  flit data.
- out_flit_type_o  out  FlitTypeWidth  flit type.
- out_broadcast_o  out  BroadcastWidth  broadcast tag.
- out_virtual_identifier_o  out  VirtualNetworkOrChannelIdWidth  source VN of the output flit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All FIFOs empty; noc_ready_o = all ones; out_valid_o = 0.
  - Data outputs = 0; arbiter pointer = VN0; lock cleared.
- Input accept: a flit is written into FIFO[vid] when noc_valid_i && noc_ready_o[vid].
  - noc_ready_o[v] = !full[v], computed from registered occupancy only; it never depends on noc_valid_i.
  - A full FIFO accepts nothing, even if it is popped in the same cycle. Ready re-asserts the following cycle.
- Out-of-range vid (vid ≥ NumberOfVirtualNetworksOrChannels): the flit is dropped and no FIFO changes.
- Flit types: HEADER=0, BODY=1, TAIL=2, HEADER_TAIL=3.
- Arbiter states:
  - IDLE: pick the first non-empty VN at or after the rr pointer whose head flit is HEADER or HEADER_TAIL. Go to LOCKED(v) in the same cycle, so out_valid_o is combinational from the FIFO head.
  - LOCKED(v): out_valid_o = !empty[v]. A pop occurs on out_valid_o && out_ready_i.
  - On popping a TAIL or HEADER_TAIL flit: go to IDLE and set the rr pointer to v+1, wrapping modulo the VN count.
- Latency: a flit accepted in cycle N is visible on out_* in cycle N+1 at the earliest.
- Head-of-line mismatch: a BODY or TAIL flit at the head of an unlocked VN is never granted; that VN stalls (protocol error, checked by the bench).
- Output stability: while out_valid_o && !out_ready_i, all out_* are held stable. A locked VN is not pre-empted by other VNs.
- Simultaneous push and pop on the same VN: both occur and occupancy is unchanged.
- Wrap-around: read and write pointers are log2(FifoDepth) bits wide. Occupancy uses an extra bit.
- Reset asserted mid-packet: all state is discarded immediately, including the partial packet and the lock.

Optional Feature:
- Macro: NETWORK_EJECTOR_STATS_EN.
- Defined: adds an output stats_flit_count_o of NumberOfVirtualNetworksOrChannels*32 bits.
  - One saturating counter per VN of flits popped to the local side.
  - Plus a 16-bit saturating stats_drop_count_o of out-of-range-vid flits.
  - All counters reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package network_ejector_pkg: the flit_type_e enum (HEADER, BODY, TAIL, HEADER_TAIL) and the helper function is_tail().
- Sub-module network_ejector_fifo: a single-VN synchronous FIFO.
  - Ports: push, pop, data in/out, full, empty.
  - Instantiated NumberOfVirtualNetworksOrChannels times.
- The arbiter and output mux stay in the top module.

Test Plan:
- Single HEADER_TAIL flit 0xA5 on VN1, out_ready_i=1 → out_valid_o high in the next cycle with flit 0xA5 and vid 1. Then out_valid_o returns to 0.
- Fill VN0 with 4 flits while out_ready_i=0 → noc_ready_o[0]=0 after the 4th accept; noc_ready_o[1] and noc_ready_o[2] stay 1.
- With VN0 full, assert out_ready_i and noc_valid_i for VN0 in the same cycle → that flit is not accepted. Ready rises the next cycle.
- Interleave 3-flit packets (H,B,T) on VN0 and VN2 flit by flit → output is the complete VN0 packet, then the complete VN2 packet. There is no interleaving.
- vid=3 with NumberOfVirtualNetworksOrChannels=3 → no output and FIFOs unchanged. With NETWORK_EJECTOR_STATS_EN, the drop count = 1.
- Assert rst mid-packet after H and B are output → out_valid_o=0 immediately and noc_ready_o = 3'b111. A new packet on VN1 is delivered intact.

Source files
------------

// File: rtl/network_ejector_pkg.sv
// Shared types and helpers for the network ejector: flit type encoding,
// arbiter state encoding and flit-type classification functions.
package network_ejector_pkg;

    typedef enum logic [1:0] {
        HEADER      = 2'd0,
        BODY        = 2'd1,
        TAIL        = 2'd2,
        HEADER_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A flit that closes a packet releases the arbiter lock.
    function automatic logic is_tail(input logic [1:0] flit_type);
        return (flit_type == 2'(TAIL)) || (flit_type == 2'(HEADER_TAIL));
    endfunction

    // A flit that may open a packet is eligible for a fresh grant.
    function automatic logic is_header(input logic [1:0] flit_type);
        return (flit_type == 2'(HEADER)) || (flit_type == 2'(HEADER_TAIL));
    endfunction

endpackage

// File: rtl/network_ejector_fifo.sv
// Single virtual-network synchronous FIFO. Pointers are log2(Depth) bits
// and wrap naturally; the occupancy counter carries one extra bit so that
// full and empty are distinguishable. Push while full and pop while empty
// are ignored.
module network_ejector_fifo #(
    parameter int DataWidth = 67,
    parameter int Depth     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full,
    output logic                 empty
);

    localparam int AddrWidth = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (AddrWidth+1)'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign data_o  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AddrWidth'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AddrWidth'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AddrWidth+1)'(1);
                2'b01:   count <= count - (AddrWidth+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are qualified by the occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/network_ejector.sv
// NoC output-port ejector: per-VN FIFOs feeding a packet-atomic round-robin
// arbiter onto a single local stream. Optional statistics counters are
// built when NETWORK_EJECTOR_STATS_EN is defined.
module network_ejector
    import network_ejector_pkg::*;
#(
    parameter int FlitWidth                         = 64,
    parameter int FlitTypeWidth                     = 2,
    parameter int BroadcastWidth                    = 1,
    parameter int VirtualNetworkOrChannelIdWidth    = 2,
    parameter int NumberOfVirtualNetworksOrChannels = 3,
    parameter int FifoDepth                         = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         noc_valid_i,
    output logic [NumberOfVirtualNetworksOrChannels-1:0] noc_ready_o,
    input  logic [FlitWidth-1:0]                         noc_flit_i,
    input  logic [FlitTypeWidth-1:0]                     noc_flit_type_i,
    input  logic [BroadcastWidth-1:0]                    noc_broadcast_i,
    input  logic [VirtualNetworkOrChannelIdWidth-1:0]    noc_virtual_identifier_i,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    output logic [FlitWidth-1:0]                         out_flit_o,
    output logic [FlitTypeWidth-1:0]                     out_flit_type_o,
    output logic [BroadcastWidth-1:0]                    out_broadcast_o,
    output logic [VirtualNetworkOrChannelIdWidth-1:0]    out_virtual_identifier_o
`ifdef NETWORK_EJECTOR_STATS_EN
    ,
    output logic [NumberOfVirtualNetworksOrChannels*32-1:0] stats_flit_count_o,
    output logic [15:0]                                     stats_drop_count_o
`endif
);

    localparam int NumVn      = NumberOfVirtualNetworksOrChannels;
    localparam int VidWidth   = VirtualNetworkOrChannelIdWidth;
    localparam int EntryWidth = BroadcastWidth + FlitTypeWidth + FlitWidth;

    logic [NumVn-1:0]      fifo_push;
    logic [NumVn-1:0]      fifo_pop;
    logic [NumVn-1:0]      fifo_full;
    logic [NumVn-1:0]      fifo_empty;
    logic [EntryWidth-1:0] fifo_head [NumVn];
    logic [EntryWidth-1:0] noc_entry;

    arb_state_e            state_q, state_d;
    logic [VidWidth-1:0]   lock_vn_q, lock_vn_d;
    logic [VidWidth-1:0]   rr_ptr_q, rr_ptr_d;

    logic                  cand_found;
    logic [VidWidth-1:0]   cand_vn;
    logic                  grant_active;
    logic [VidWidth-1:0]   grant_vn;
    logic [EntryWidth-1:0] sel_head;
    logic                  sel_empty;
    logic                  pop_fire;

    // FIFO entries pack broadcast, type and payload; the VN is implied by
    // which FIFO holds the flit.
    assign noc_entry   = {noc_broadcast_i, noc_flit_type_i, noc_flit_i};
    assign noc_ready_o = ~fifo_full;

    // Route an accepted flit to the FIFO named by its VN; out-of-range VNs
    // match no FIFO and are dropped.
    always_comb begin
        fifo_push = '0;
        for (int v = 0; v < NumVn; v++) begin
            fifo_push[v] = noc_valid_i && !fifo_full[v]
                           && (int'(noc_virtual_identifier_i) == v);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NumVn; g++) begin : gen_vn_fifo
            network_ejector_fifo #(
                .DataWidth (EntryWidth),
                .Depth     (FifoDepth)
            ) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .push   (fifo_push[g]),
                .pop    (fifo_pop[g]),
                .data_i (noc_entry),
                .data_o (fifo_head[g]),
                .full   (fifo_full[g]),
                .empty  (fifo_empty[g])
            );
        end
    endgenerate

    // Grant selection: keep the locked VN, otherwise search round-robin from
    // the pointer for a VN whose head flit opens a packet.
    always_comb begin
        int idx;
        idx        = 0;
        cand_found = 1'b0;
        cand_vn    = '0;
        for (int i = 0; i < NumVn; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NumVn) idx = idx - NumVn;
            if (!cand_found && !fifo_empty[idx]
                && is_header(fifo_head[idx][FlitWidth +: FlitTypeWidth])) begin
                cand_found = 1'b1;
                cand_vn    = VidWidth'(idx);
            end
        end
        if (state_q == ARB_LOCKED) begin
            grant_active = 1'b1;
            grant_vn     = lock_vn_q;
        end else begin
            grant_active = cand_found;
            grant_vn     = cand_vn;
        end
    end

    // Output mux and pop generation; data outputs read zero when idle.
    always_comb begin
        sel_head  = '0;
        sel_empty = 1'b1;
        for (int v = 0; v < NumVn; v++) begin
            if (int'(grant_vn) == v) begin
                sel_head  = fifo_head[v];
                sel_empty = fifo_empty[v];
            end
        end
        out_valid_o = grant_active && !sel_empty;
        pop_fire    = out_valid_o && out_ready_i;
        fifo_pop    = '0;
        for (int v = 0; v < NumVn; v++) begin
            fifo_pop[v] = pop_fire && (int'(grant_vn) == v);
        end
        out_flit_o               = out_valid_o ? sel_head[FlitWidth-1:0] : '0;
        out_flit_type_o          = out_valid_o ? sel_head[FlitWidth +: FlitTypeWidth] : '0;
        out_broadcast_o          = out_valid_o ? sel_head[EntryWidth-1 -: BroadcastWidth] : '0;
        out_virtual_identifier_o = out_valid_o ? grant_vn : '0;
    end

    // Arbiter next state: release and advance the pointer on a packet's last
    // flit, otherwise hold (or take) the lock on the granted VN.
    always_comb begin
        state_d   = state_q;
        lock_vn_d = lock_vn_q;
        rr_ptr_d  = rr_ptr_q;
        if (pop_fire && is_tail(sel_head[FlitWidth +: FlitTypeWidth])) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (int'(grant_vn) == NumVn - 1) ? '0 : grant_vn + VidWidth'(1);
        end else if (grant_active) begin
            state_d   = ARB_LOCKED;
            lock_vn_d = grant_vn;
        end
    end

    // Arbiter state register; reset discards any lock immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            lock_vn_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_vn_q <= lock_vn_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef NETWORK_EJECTOR_STATS_EN
    logic [31:0] flit_cnt_q [NumVn];
    logic [15:0] drop_cnt_q;
    logic        vid_out_of_range;

    assign vid_out_of_range = int'(noc_virtual_identifier_i) >= NumVn;

    // Saturating per-VN delivered-flit counters and dropped-flit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NumVn; v++) flit_cnt_q[v] <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int v = 0; v < NumVn; v++) begin
                if (fifo_pop[v] && (flit_cnt_q[v] != '1)) flit_cnt_q[v] <= flit_cnt_q[v] + 32'd1;
            end
            if (noc_valid_i && vid_out_of_range && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    // Flatten the per-VN counters onto the statistics port.
    always_comb begin
        stats_flit_count_o = '0;
        for (int v = 0; v < NumVn; v++) stats_flit_count_o[v*32 +: 32] = flit_cnt_q[v];
        stats_drop_count_o = drop_cnt_q;
    end
`endif

endmodule

// File: tb/tb_network_ejector.sv
// Directed bench for network_ejector: single-flit delivery, back-pressure,
// full-FIFO accept rule, packet atomicity, out-of-range drop, reset
// mid-packet and head-of-line stall. Checks the statistics ports when
// NETWORK_EJECTOR_STATS_EN is defined.
module tb_network_ejector;

    logic        clk = 1'b0;
    logic        rst;
    logic        noc_valid_i;
    logic [2:0]  noc_ready_o;
    logic [63:0] noc_flit_i;
    logic [1:0]  noc_flit_type_i;
    logic [0:0]  noc_broadcast_i;
    logic [1:0]  noc_virtual_identifier_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_flit_o;
    logic [1:0]  out_flit_type_o;
    logic [0:0]  out_broadcast_o;
    logic [1:0]  out_virtual_identifier_o;
`ifdef NETWORK_EJECTOR_STATS_EN
    logic [95:0] stats_flit_count_o;
    logic [15:0] stats_drop_count_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    network_ejector dut (
        .clk                      (clk),
        .rst                      (rst),
        .noc_valid_i              (noc_valid_i),
        .noc_ready_o              (noc_ready_o),
        .noc_flit_i               (noc_flit_i),
        .noc_flit_type_i          (noc_flit_type_i),
        .noc_broadcast_i          (noc_broadcast_i),
        .noc_virtual_identifier_i (noc_virtual_identifier_i),
        .out_valid_o              (out_valid_o),
        .out_ready_i              (out_ready_i),
        .out_flit_o               (out_flit_o),
        .out_flit_type_o          (out_flit_type_o),
        .out_broadcast_o          (out_broadcast_o),
        .out_virtual_identifier_o (out_virtual_identifier_o)
`ifdef NETWORK_EJECTOR_STATS_EN
        ,
        .stats_flit_count_o       (stats_flit_count_o),
        .stats_drop_count_o       (stats_drop_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] vid, input logic [1:0] t, input logic [63:0] d);
        noc_valid_i              = v;
        noc_virtual_identifier_i = vid;
        noc_flit_type_i          = t;
        noc_flit_i               = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_flit [6];
    logic [1:0]  exp_vid  [6];
    logic [1:0]  exp_type [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready_i = 1'b0;
        noc_broadcast_i = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_noc_ready", {61'd0, noc_ready_o}, 64'h7);
        chk("rst_out_flit", out_flit_o, 64'h0);
        rst = 1'b0;

        // Single HEADER_TAIL flit on VN1
        out_ready_i = 1'b1;
        noc_broadcast_i = 1'b1;
        drive(1'b1, 2'd1, 2'd3, 64'hA5);
        #1;
        chk("t1_pre_valid", {63'd0, out_valid_o}, 64'd0);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        noc_broadcast_i = 1'b0;
        chk("t1_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t1_flit", out_flit_o, 64'hA5);
        chk("t1_vid", {62'd0, out_virtual_identifier_o}, 64'd1);
        chk("t1_type", {62'd0, out_flit_type_o}, 64'd3);
        chk("t1_bcast", {63'd0, out_broadcast_o}, 64'd1);
        step();
        chk("t1_after_valid", {63'd0, out_valid_o}, 64'd0);

        // Fill VN0 with back-pressure applied
        out_ready_i = 1'b0;
        drive(1'b1, 2'd0, 2'd0, 64'h10); step();
        drive(1'b1, 2'd0, 2'd1, 64'h11); step();
        drive(1'b1, 2'd0, 2'd1, 64'h12); step();
        drive(1'b1, 2'd0, 2'd2, 64'h13);
        chk("t2_ready_3of4", {61'd0, noc_ready_o}, 64'h7);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t2_ready_full", {61'd0, noc_ready_o}, 64'h6);
        chk("t2_hold_valid", {63'd0, out_valid_o}, 64'd1);
        chk("t2_hold_flit", out_flit_o, 64'h10);
        step();
        chk("t2_still_flit", out_flit_o, 64'h10);

        // Full FIFO ignores a push even when popped in the same cycle
        drive(1'b1, 2'd0, 2'd1, 64'hEE);
        out_ready_i = 1'b1;
        #1;
        chk("t3_ready_low", {61'd0, noc_ready_o}, 64'h6);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        out_ready_i = 1'b0;
        chk("t3_ready_back", {61'd0, noc_ready_o}, 64'h7);
        chk("t3_flit_b1", out_flit_o, 64'h11);
        out_ready_i = 1'b1;
        step();
        chk("t3_flit_b2", out_flit_o, 64'h12);
        step();
        chk("t3_flit_t", out_flit_o, 64'h13);
        chk("t3_type_t", {62'd0, out_flit_type_o}, 64'd2);
        step();
        chk("t3_no_extra", {63'd0, out_valid_o}, 64'd0);

        // Interleaved 3-flit packets on VN0 and VN2
        out_ready_i = 1'b0;
        drive(1'b1, 2'd0, 2'd0, 64'h20); step();
        drive(1'b1, 2'd2, 2'd0, 64'h40); step();
        drive(1'b1, 2'd0, 2'd1, 64'h21); step();
        drive(1'b1, 2'd2, 2'd1, 64'h41); step();
        drive(1'b1, 2'd0, 2'd2, 64'h22); step();
        drive(1'b1, 2'd2, 2'd2, 64'h42); step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        exp_flit = '{64'h20, 64'h21, 64'h22, 64'h40, 64'h41, 64'h42};
        exp_vid  = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
        exp_type = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_flit%0d", i), out_flit_o, exp_flit[i]);
            chk($sformatf("t4_vid%0d", i), {62'd0, out_virtual_identifier_o}, {62'd0, exp_vid[i]});
            chk($sformatf("t4_type%0d", i), {62'd0, out_flit_type_o}, {62'd0, exp_type[i]});
            step();
        end
        chk("t4_done", {63'd0, out_valid_o}, 64'd0);

        // Out-of-range VN is dropped
        drive(1'b1, 2'd3, 2'd3, 64'h77);
        #1;
        chk("t5_ready", {61'd0, noc_ready_o}, 64'h7);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t5_no_out", {63'd0, out_valid_o}, 64'd0);
        chk("t5_ready_after", {61'd0, noc_ready_o}, 64'h7);
        step();
        chk("t5_no_out2", {63'd0, out_valid_o}, 64'd0);
`ifdef NETWORK_EJECTOR_STATS_EN
        chk("t5_drop_cnt", {48'd0, stats_drop_count_o}, 64'd1);
        chk("t5_vn0_cnt", {32'd0, stats_flit_count_o[31:0]}, 64'd7);
        chk("t5_vn1_cnt", {32'd0, stats_flit_count_o[63:32]}, 64'd1);
        chk("t5_vn2_cnt", {32'd0, stats_flit_count_o[95:64]}, 64'd3);
`endif

        // Reset asserted mid-packet on VN1
        drive(1'b1, 2'd1, 2'd0, 64'h50); step();
        drive(1'b1, 2'd1, 2'd1, 64'h51);
        chk("t6_h", out_flit_o, 64'h50);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t6_b", out_flit_o, 64'h51);
        step();
        chk("t6_gap", {63'd0, out_valid_o}, 64'd0);
        out_ready_i = 1'b0;
        drive(1'b1, 2'd1, 2'd2, 64'h52); step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t6_tail_pending", out_flit_o, 64'h52);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("t6_rst_ready", {61'd0, noc_ready_o}, 64'h7);
        chk("t6_rst_flit", out_flit_o, 64'h0);
        step();
        rst = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b1, 2'd1, 2'd0, 64'h60); step();
        drive(1'b1, 2'd1, 2'd2, 64'h61);
        chk("t6_new_h", out_flit_o, 64'h60);
        chk("t6_new_vid", {62'd0, out_virtual_identifier_o}, 64'd1);
        step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t6_new_t", out_flit_o, 64'h61);
        step();
        chk("t6_new_done", {63'd0, out_valid_o}, 64'd0);

        // BODY at the head of an unlocked VN stalls; other VNs still flow
        drive(1'b1, 2'd2, 2'd1, 64'h90); step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t7_stall", {63'd0, out_valid_o}, 64'd0);
        step();
        chk("t7_stall2", {63'd0, out_valid_o}, 64'd0);
        drive(1'b1, 2'd0, 2'd3, 64'h91); step();
        drive(1'b0, 2'd0, 2'd0, 64'h0);
        chk("t7_other_flit", out_flit_o, 64'h91);
        chk("t7_other_vid", {62'd0, out_virtual_identifier_o}, 64'd0);
        step();
        chk("t7_end", {63'd0, out_valid_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
